sys_rst_seq: RTL and testbench

SYS_RST_SEQ -- requirements
Module: sys_rst_seq

---
 rtl/sys_rst_pkg.sv | 24 ++
 rtl/cdc_sync2.sv | 25 ++
 rtl/sys_rst_seq.sv | 169 ++++++++++++++++
 tb/tb_sys_rst_seq.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/sys_rst_pkg.sv
// Shared state encoding and default timing constants for the reset sequencer.
package sys_rst_pkg;

  typedef enum logic [2:0] {
    ST_PLL_RST   = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_RELEASE   = 3'd2,
    ST_RUN       = 3'd3,
    ST_FAIL      = 3'd4
  } state_e;

  localparam int unsigned PLL_RST_CYC_DEF      = 32'd16;
  localparam int unsigned LOCK_STABLE_CYC_DEF  = 32'd64;
  localparam int unsigned LOCK_TIMEOUT_CYC_DEF = 32'd4096;
  localparam int unsigned N_STAGES_DEF         = 32'd3;
  localparam int unsigned STAGE_GAP_DEF        = 32'd8;
  localparam int unsigned MAX_RETRY_DEF        = 32'd3;

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    return (a > b) ? ((a > c) ? a : c) : ((b > c) ? b : c);
  endfunction

endpackage

// File: rtl/cdc_sync2.sv
// Two-flop synchronizer for a single asynchronous level.
module cdc_sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  // Two-stage capture of the asynchronous input.
  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/sys_rst_seq.sv
// PLL reset / lock-qualification sequencer with staged, in-order reset release.
module sys_rst_seq
  import sys_rst_pkg::*;
#(
  parameter int unsigned PLL_RST_CYC      = PLL_RST_CYC_DEF,
  parameter int unsigned LOCK_STABLE_CYC  = LOCK_STABLE_CYC_DEF,
  parameter int unsigned LOCK_TIMEOUT_CYC = LOCK_TIMEOUT_CYC_DEF,
  parameter int unsigned N_STAGES         = N_STAGES_DEF,
  parameter int unsigned STAGE_GAP        = STAGE_GAP_DEF,
  parameter int unsigned MAX_RETRY        = MAX_RETRY_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                pll_locked,
  output logic                pll_rst,
  output logic [N_STAGES-1:0] stage_rst,
  output logic                sys_ready,
  output logic                lock_lost,
  output logic                pll_fail,
  output logic [1:0]          retry_cnt
);

  localparam int PW = $clog2(max3(PLL_RST_CYC, LOCK_TIMEOUT_CYC, STAGE_GAP) + 1);
  localparam int SW = $clog2(LOCK_STABLE_CYC + 1);
  localparam int RW = $clog2(MAX_RETRY + 1);

  logic lock_s;

  cdc_sync2 u_lock_sync (
    .clk (clk),
    .rst (rst),
    .d   (pll_locked),
    .q   (lock_s)
  );

  state_e              state_q,   state_d;
  logic [PW-1:0]       cnt_q,     cnt_d;
  logic [SW-1:0]       stable_q,  stable_d;
  logic [RW-1:0]       retry_q,   retry_d;
  logic                pll_rst_q, pll_rst_d;
  logic [N_STAGES-1:0] stage_q,   stage_d;
  logic                ready_q,   ready_d;
  logic                lost_q,    lost_d;
  logic                fail_q,    fail_d;

  logic          accept_s;
  logic          timeout_s;
  logic [RW-1:0] retry_inc_s;

  // Acceptance is checked before timeout so a coincident cycle still releases.
  assign accept_s    = lock_s && (stable_q == SW'(LOCK_STABLE_CYC - 1));
  assign timeout_s   = (cnt_q == PW'(LOCK_TIMEOUT_CYC - 1));
  assign retry_inc_s = retry_q + RW'(1);

  // Next-state and next-output computation.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    stable_d  = '0;
    retry_d   = retry_q;
    pll_rst_d = pll_rst_q;
    stage_d   = stage_q;
    ready_d   = 1'b0;
    lost_d    = lost_q;
    fail_d    = 1'b0;
    case (state_q)
      ST_PLL_RST: begin
        pll_rst_d = 1'b1;
        stage_d   = '1;
        if (cnt_q == PW'(PLL_RST_CYC - 1)) begin
          state_d   = ST_WAIT_LOCK;
          cnt_d     = '0;
          pll_rst_d = 1'b0;
        end else begin
          cnt_d = cnt_q + PW'(1);
        end
      end
      ST_WAIT_LOCK: begin
        if (lock_s) begin
          stable_d = (stable_q == SW'(LOCK_STABLE_CYC)) ? stable_q : stable_q + SW'(1);
        end else begin
          stable_d = '0;
        end
        if (accept_s) begin
          state_d  = ST_RELEASE;
          cnt_d    = '0;
          stable_d = '0;
          stage_d  = stage_q << 1'b1;
        end else if (timeout_s) begin
          cnt_d    = '0;
          stable_d = '0;
          retry_d  = retry_inc_s;
          if (retry_inc_s == RW'(MAX_RETRY)) begin
            state_d = ST_FAIL;
            fail_d  = 1'b1;
          end else begin
            state_d   = ST_PLL_RST;
            pll_rst_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + PW'(1);
        end
      end
      ST_RELEASE, ST_RUN: begin
        if (!lock_s) begin
          state_d   = ST_PLL_RST;
          cnt_d     = '0;
          retry_d   = '0;
          pll_rst_d = 1'b1;
          stage_d   = '1;
          lost_d    = 1'b1;
        end else if (state_q == ST_RUN || stage_q == '0) begin
          state_d = ST_RUN;
          ready_d = 1'b1;
        end else if (cnt_q == PW'(STAGE_GAP - 1)) begin
          // Shifting in zeros from the LSB keeps releases strictly in order.
          stage_d = stage_q << 1'b1;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + PW'(1);
        end
      end
      ST_FAIL: begin
        pll_rst_d = 1'b0;
        stage_d   = '1;
        fail_d    = 1'b1;
      end
      default: begin
        state_d   = ST_PLL_RST;
        cnt_d     = '0;
        pll_rst_d = 1'b1;
        stage_d   = '1;
      end
    endcase
  end

  // Sequencer state and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_PLL_RST;
      cnt_q     <= '0;
      stable_q  <= '0;
      retry_q   <= '0;
      pll_rst_q <= 1'b1;
      stage_q   <= '1;
      ready_q   <= 1'b0;
      lost_q    <= 1'b0;
      fail_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      stable_q  <= stable_d;
      retry_q   <= retry_d;
      pll_rst_q <= pll_rst_d;
      stage_q   <= stage_d;
      ready_q   <= ready_d;
      lost_q    <= lost_d;
      fail_q    <= fail_d;
    end
  end

  assign pll_rst   = pll_rst_q;
  assign stage_rst = stage_q;
  assign sys_ready = ready_q;
  assign lock_lost = lost_q;
  assign pll_fail  = fail_q;
  assign retry_cnt = 2'(retry_q);

endmodule

// File: tb/tb_sys_rst_seq.sv
// Directed, table-driven bench for sys_rst_seq at default parameters.
module tb_sys_rst_seq;

  localparam int NEVER = 32'h7fff_ffff;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       pll_locked = 1'b0;
  logic       pll_rst;
  logic [2:0] stage_rst;
  logic       sys_ready;
  logic       lock_lost;
  logic       pll_fail;
  logic [1:0] retry_cnt;

  sys_rst_seq dut (
    .clk        (clk),
    .rst        (rst),
    .pll_locked (pll_locked),
    .pll_rst    (pll_rst),
    .stage_rst  (stage_rst),
    .sys_ready  (sys_ready),
    .lock_lost  (lock_lost),
    .pll_fail   (pll_fail),
    .retry_cnt  (retry_cnt)
  );

  always #5 clk = ~clk;

  // Expected outputs after clock edge 'cyc': {pll_rst, stage_rst, sys_ready, lock_lost, pll_fail, retry_cnt}
  typedef struct {
    int         cyc;
    logic [8:0] exp;
  } vec_t;

  vec_t vecs[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic add(input int cyc, input logic pr, input logic [2:0] st, input logic rd,
                     input logic ls, input logic fl, input logic [1:0] rt);
    vec_t v;
    v.cyc = cyc;
    v.exp = {pr, st, rd, ls, fl, rt};
    vecs.push_back(v);
  endtask

  // Leaves rst low just after the last reset edge; that state is cycle 0.
  task automatic do_reset();
    rst        = 1'b1;
    pll_locked = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Inputs set at cycle c are sampled by edge c+1.
  task automatic run(input string name, input int rise, input int glitch, input int drop,
                     input int relock, input int rst_at, input int last);
    int         vi;
    logic [8:0] got;
    vi = 0;
    for (int cyc = 0; cyc <= last; cyc++) begin
      got = {pll_rst, stage_rst, sys_ready, lock_lost, pll_fail, retry_cnt};
      n_checks++;
      if (stage_rst inside {3'b111, 3'b110, 3'b100, 3'b000}) n_pass++;
      else $display("FAIL %s order cyc=%0d stage_rst=%b", name, cyc, stage_rst);
      while (vi < vecs.size() && vecs[vi].cyc == cyc) begin
        n_checks++;
        if (got === vecs[vi].exp) n_pass++;
        else $display("FAIL %s cyc=%0d {pll_rst,stage,ready,lost,fail,retry} got=%b required=%b",
                      name, cyc, got, vecs[vi].exp);
        vi++;
      end
      pll_locked = (cyc >= rise) && (cyc != glitch) && !(cyc >= drop && cyc < relock);
      rst        = (cyc == rst_at);
      @(posedge clk);
      #1;
    end
    if (vi != vecs.size()) begin
      n_checks++;
      $display("FAIL %s unreached_vectors got=%0d required=0", name, vecs.size() - vi);
    end
    vecs.delete();
  endtask

  initial begin
    // Normal lock at 30, lock loss in RUN at 200, relock at 250.
    do_reset();
    add(0,   1'b1, 3'b111, 1'b0, 1'b0, 1'b0, 2'd0);
    add(15,  1'b1, 3'b111, 1'b0, 1'b0, 1'b0, 2'd0);
    add(16,  1'b0, 3'b111, 1'b0, 1'b0, 1'b0, 2'd0);
    add(95,  1'b0, 3'b111, 1'b0, 1'b0, 1'b0, 2'd0);
    add(96,  1'b0, 3'b110, 1'b0, 1'b0, 1'b0, 2'd0);
    add(103, 1'b0, 3'b110, 1'b0, 1'b0, 1'b0, 2'd0);
    add(104, 1'b0, 3'b100, 1'b0, 1'b0, 1'b0, 2'd0);
    add(111, 1'b0, 3'b100, 1'b0, 1'b0, 1'b0, 2'd0);
    add(112, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 2'd0);
    add(113, 1'b0, 3'b000, 1'b1, 1'b0, 1'b0, 2'd0);
    add(202, 1'b0, 3'b000, 1'b1, 1'b0, 1'b0, 2'd0);
    add(203, 1'b1, 3'b111, 1'b0, 1'b1, 1'b0, 2'd0);
    add(218, 1'b1, 3'b111, 1'b0, 1'b1, 1'b0, 2'd0);
    add(219, 1'b0, 3'b111, 1'b0, 1'b1, 1'b0, 2'd0);
    add(315, 1'b0, 3'b111, 1'b0, 1'b1, 1'b0, 2'd0);
    add(316, 1'b0, 3'b110, 1'b0, 1'b1, 1'b0, 2'd0);
    add(324, 1'b0, 3'b100, 1'b0, 1'b1, 1'b0, 2'd0);
    add(332, 1'b0, 3'b000, 1'b0, 1'b1, 1'b0, 2'd0);
    add(333, 1'b0, 3'b000, 1'b1, 1'b1, 1'b0, 2'd0);
    add(340, 1'b0, 3'b000, 1'b1, 1'b1, 1'b0, 2'd0);
    run("lock_seq", 30, NEVER, 200, 250, NEVER, 340);

    // One-cycle glitch at stable count 50, then rst between stage 1 and stage 2.
    do_reset();
    add(0,   1'b1, 3'b111, 1'b0, 1'b0, 1'b0, 2'd0);
    add(96,  1'b0, 3'b111, 1'b0, 1'b0, 1'b0, 2'd0);
    add(146, 1'b0, 3'b111, 1'b0, 1'b0, 1'b0, 2'd0);
    add(147, 1'b0, 3'b110, 1'b0, 1'b0, 1'b0, 2'd0);
    add(155, 1'b0, 3'b100, 1'b0, 1'b0, 1'b0, 2'd0);
    add(158, 1'b0, 3'b100, 1'b0, 1'b0, 1'b0, 2'd0);
    add(159, 1'b1, 3'b111, 1'b0, 1'b0, 1'b0, 2'd0);
    add(174, 1'b1, 3'b111, 1'b0, 1'b0, 1'b0, 2'd0);
    add(175, 1'b0, 3'b111, 1'b0, 1'b0, 1'b0, 2'd0);
    run("glitch_rst", 30, 80, NEVER, NEVER, 158, 180);

    // Lock never arrives in time: three timeouts lead to terminal FAIL.
    do_reset();
    add(0,     1'b1, 3'b111, 1'b0, 1'b0, 1'b0, 2'd0);
    add(16,    1'b0, 3'b111, 1'b0, 1'b0, 1'b0, 2'd0);
    add(4111,  1'b0, 3'b111, 1'b0, 1'b0, 1'b0, 2'd0);
    add(4112,  1'b1, 3'b111, 1'b0, 1'b0, 1'b0, 2'd1);
    add(4127,  1'b1, 3'b111, 1'b0, 1'b0, 1'b0, 2'd1);
    add(4128,  1'b0, 3'b111, 1'b0, 1'b0, 1'b0, 2'd1);
    add(8223,  1'b0, 3'b111, 1'b0, 1'b0, 1'b0, 2'd1);
    add(8224,  1'b1, 3'b111, 1'b0, 1'b0, 1'b0, 2'd2);
    add(8240,  1'b0, 3'b111, 1'b0, 1'b0, 1'b0, 2'd2);
    add(12335, 1'b0, 3'b111, 1'b0, 1'b0, 1'b0, 2'd2);
    add(12336, 1'b0, 3'b111, 1'b0, 1'b0, 1'b1, 2'd3);
    add(12400, 1'b0, 3'b111, 1'b0, 1'b0, 1'b1, 2'd3);
    run("no_lock", 12350, NEVER, NEVER, NEVER, NEVER, 12400);

    // Stable count reaches 64 on the very cycle the first timeout expires.
    do_reset();
    add(0,    1'b1, 3'b111, 1'b0, 1'b0, 1'b0, 2'd0);
    add(4111, 1'b0, 3'b111, 1'b0, 1'b0, 1'b0, 2'd0);
    add(4112, 1'b0, 3'b110, 1'b0, 1'b0, 1'b0, 2'd0);
    add(4120, 1'b0, 3'b100, 1'b0, 1'b0, 1'b0, 2'd0);
    add(4128, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 2'd0);
    add(4129, 1'b0, 3'b000, 1'b1, 1'b0, 1'b0, 2'd0);
    run("coincide", 4046, NEVER, NEVER, NEVER, NEVER, 4135);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
